// File: rtl/piece_redraw_seq_pkg.sv
// Shared types and constants for the piece redraw sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package redraw_pkg;

    // Top-level job class the sequencer is working through.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ERASE,
        ST_DRAW
    } state_e;

    // Each busy state alternates between issuing a job and waiting for it.
    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    // Upper bound on cells per piece; sizes the cell index counter.
    localparam int MAX_CELLS = 8;

    localparam logic [8:0] COLOR_BG      = 9'd0;
    localparam logic [8:0] COLOR_MAGENTA = 9'b111_000_111;

    // True when a cell lies on the visible board.
    function automatic logic cell_in_grid(input int cx, input int cy,
                                          input int gw, input int gh);
        return (cx < gw) && (cy < gh);
    endfunction

endpackage

// File: rtl/piece_redraw_seq_if.sv
// Painter job handshake: one kick per job, painter answers with busy/done.
// Latency: wires only.
// Backpressure: the master must not kick while painter_busy is high.
//   kick          master->slave  1-cycle job start
//   x0, y0        master->slave  job pixel origin, valid with kick
//   paint_color   master->slave  job colour, valid with kick
//   painter_busy  slave->master  job in progress
//   painter_done  slave->master  1-cycle pulse at job end
interface piece_redraw_seq_if #(
    parameter int COLOR_W = 9
) ();
    logic               kick;
    logic [9:0]         x0;
    logic [8:0]         y0;
    logic [COLOR_W-1:0] paint_color;
    logic               painter_busy;
    logic               painter_done;

    modport master (
        output kick, x0, y0, paint_color,
        input  painter_busy, painter_done
    );

    modport slave (
        input  kick, x0, y0, paint_color,
        output painter_busy, painter_done
    );
endinterface

// File: rtl/piece_redraw_seq_cell_to_pixel.sv
// Converts a board cell coordinate to the painter's pixel origin.
// Latency: combinational.
// Backpressure: none.
//   i_cx, i_cy  cell column / row
//   o_x0        cx << CELL_W_LOG2, truncated to 10 bits
//   o_y0        cy * CELL_H, truncated to 9 bits
module cell_to_pixel #(
    parameter int XW          = 4,
    parameter int YW          = 5,
    parameter int CELL_W_LOG2 = 6,
    parameter int CELL_H      = 24
) (
    input  logic [XW-1:0] i_cx,
    input  logic [YW-1:0] i_cy,
    output logic [9:0]    o_x0,
    output logic [8:0]    o_y0
);
    assign o_x0 = 10'(32'(i_cx) << CELL_W_LOG2);
    assign o_y0 = 9'(32'(i_cy) * CELL_H);
endmodule

// File: rtl/piece_redraw_seq.sv
// Sequences painter jobs for board clear, piece erase and piece draw.
// Latency: request in IDLE -> decision next cycle -> first kick the cycle after.
// Backpressure: one job in flight; kicks wait for painter_busy low, requests stay pending.
//   CLOCK_50, resetn        clock, async active-low reset
//   req_move, req_clear     1-cycle request pulses, latched as sticky pending flags
//   cur_x, cur_y            packed new cell coordinates, sampled at the IDLE snapshot
//   piece_color, bg_color   draw colour (snapshotted) and erase/clear colour
//   pif                     painter job handshake (master side)
//   idle                    IDLE with nothing pending
module piece_redraw_seq
    import redraw_pkg::*;
#(
    parameter int NCELLS         = 4,
    parameter int GRID_W         = 10,
    parameter int GRID_H         = 20,
    parameter int XW             = 4,
    parameter int YW             = 5,
    parameter int CELL_W_LOG2    = 6,
    parameter int CELL_H         = 24,
    parameter int COLOR_W        = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 req_move,
    input  logic                 req_clear,
    input  logic [NCELLS*XW-1:0] cur_x,
    input  logic [NCELLS*YW-1:0] cur_y,
    input  logic [COLOR_W-1:0]   piece_color,
    input  logic [COLOR_W-1:0]   bg_color,
    piece_redraw_seq_if.master   pif,
    output logic                 idle
);
    localparam int IW = $clog2(MAX_CELLS + 1);

    state_e               r_state;
    phase_e               r_phase;
    logic [IW-1:0]        r_idx;
    logic [XW-1:0]        r_clr_x;
    logic [YW-1:0]        r_clr_y;
    logic [NCELLS*XW-1:0] r_prev_x;
    logic [NCELLS*YW-1:0] r_prev_y;
    logic [NCELLS*XW-1:0] r_new_x;
    logic [NCELLS*YW-1:0] r_new_y;
    logic [COLOR_W-1:0]   r_new_color;
    logic                 r_prev_valid;
    logic                 r_pend_move;
    logic                 r_pend_clear;
    logic                 r_kick;
    logic [9:0]           r_x0;
    logic [8:0]           r_y0;
    logic [COLOR_W-1:0]   r_color;

    logic [NCELLS-1:0]    w_erase_skip;
    logic [NCELLS-1:0]    w_draw_skip;
    logic [NCELLS-1:0]    w_skip;
    logic                 w_found;
    logic [IW-1:0]        w_sel;
    logic [XW-1:0]        w_job_cx;
    logic [YW-1:0]        w_job_cy;
    logic [COLOR_W-1:0]   w_job_color;
    logic [9:0]           w_px;
    logic [8:0]           w_py;
    logic                 w_can_kick;

    // A previous cell is left alone if it is off-board or the new piece
    // still covers it (it will be redrawn anyway, so erasing would flicker).
    always_comb begin
        w_erase_skip = '0;
        w_draw_skip  = '0;
        for (int i = 0; i < NCELLS; i++) begin
            w_draw_skip[i]  = !cell_in_grid(int'(r_new_x[i*XW +: XW]),
                                            int'(r_new_y[i*YW +: YW]), GRID_W, GRID_H);
            w_erase_skip[i] = !cell_in_grid(int'(r_prev_x[i*XW +: XW]),
                                            int'(r_prev_y[i*YW +: YW]), GRID_W, GRID_H);
            for (int j = 0; j < NCELLS; j++) begin
                if (r_prev_x[i*XW +: XW] == r_new_x[j*XW +: XW] &&
                    r_prev_y[i*YW +: YW] == r_new_y[j*YW +: YW])
                    w_erase_skip[i] = 1'b1;
            end
        end
    end

    assign w_skip = (r_state == ST_ERASE) ? w_erase_skip : w_draw_skip;

    // First non-skipped cell at or after r_idx; skipped cells cost no cycles.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int j = 0; j < NCELLS; j++) begin
            if (!w_found && IW'(j) >= r_idx && !w_skip[j]) begin
                w_found = 1'b1;
                w_sel   = IW'(j);
            end
        end
    end

    // Current job mux feeding the single coordinate converter.
    always_comb begin
        w_job_cx    = r_clr_x;
        w_job_cy    = r_clr_y;
        w_job_color = bg_color;
        case (r_state)
            ST_ERASE: begin
                w_job_cx = r_prev_x[w_sel*XW +: XW];
                w_job_cy = r_prev_y[w_sel*YW +: YW];
            end
            ST_DRAW: begin
                w_job_cx    = r_new_x[w_sel*XW +: XW];
                w_job_cy    = r_new_y[w_sel*YW +: YW];
                w_job_color = r_new_color;
            end
            default: ;
        endcase
    end

    cell_to_pixel #(
        .XW          (XW),
        .YW          (YW),
        .CELL_W_LOG2 (CELL_W_LOG2),
        .CELL_H      (CELL_H)
    ) u_cell_to_pixel (
        .i_cx (w_job_cx),
        .i_cy (w_job_cy),
        .o_x0 (w_px),
        .o_y0 (w_py)
    );

    // r_kick guard keeps a gap cycle so the painter can raise busy.
    assign w_can_kick = !pif.painter_busy && !r_kick;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_phase      <= PH_ISSUE;
            r_idx        <= '0;
            r_clr_x      <= '0;
            r_clr_y      <= '0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_new_x      <= '0;
            r_new_y      <= '0;
            r_new_color  <= '0;
            r_prev_valid <= 1'b0;
            r_pend_move  <= 1'b0;
            r_pend_clear <= (CLEAR_ON_RESET != 0);
            r_kick       <= 1'b0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_color      <= '0;
        end else begin
            r_kick       <= 1'b0;
            r_pend_move  <= r_pend_move  | req_move;
            r_pend_clear <= r_pend_clear | req_clear;

            case (r_state)
                ST_IDLE: begin
                    r_phase <= PH_ISSUE;
                    r_idx   <= '0;
                    if (r_pend_clear) begin
                        // A request arriving this same cycle stays pending.
                        r_pend_clear <= req_clear;
                        r_clr_x      <= '0;
                        r_clr_y      <= '0;
                        r_state      <= ST_CLEAR;
                    end else if (r_pend_move) begin
                        r_pend_move <= req_move;
                        r_new_x     <= cur_x;
                        r_new_y     <= cur_y;
                        r_new_color <= piece_color;
                        r_state     <= r_prev_valid ? ST_ERASE : ST_DRAW;
                    end
                end

                ST_CLEAR: begin
                    if (r_phase == PH_ISSUE) begin
                        if (w_can_kick) begin
                            r_kick  <= 1'b1;
                            r_x0    <= w_px;
                            r_y0    <= w_py;
                            r_color <= w_job_color;
                            r_phase <= PH_WAIT;
                        end
                    end else if (pif.painter_done) begin
                        r_phase <= PH_ISSUE;
                        if (r_clr_x == XW'(GRID_W - 1)) begin
                            r_clr_x <= '0;
                            if (r_clr_y == YW'(GRID_H - 1)) begin
                                r_prev_valid <= 1'b0;
                                r_state      <= ST_IDLE;
                            end else begin
                                r_clr_y <= r_clr_y + YW'(1);
                            end
                        end else begin
                            r_clr_x <= r_clr_x + XW'(1);
                        end
                    end
                end

                ST_ERASE, ST_DRAW: begin
                    if (r_phase == PH_ISSUE) begin
                        if (!w_found) begin
                            r_idx <= '0;
                            if (r_state == ST_ERASE) begin
                                r_state <= ST_DRAW;
                            end else begin
                                r_prev_x     <= r_new_x;
                                r_prev_y     <= r_new_y;
                                r_prev_valid <= 1'b1;
                                r_state      <= ST_IDLE;
                            end
                        end else if (w_can_kick) begin
                            r_kick  <= 1'b1;
                            r_x0    <= w_px;
                            r_y0    <= w_py;
                            r_color <= w_job_color;
                            r_idx   <= w_sel;
                            r_phase <= PH_WAIT;
                        end
                    end else if (pif.painter_done) begin
                        r_idx   <= r_idx + IW'(1);
                        r_phase <= PH_ISSUE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pif.kick        = r_kick;
    assign pif.x0          = r_x0;
    assign pif.y0          = r_y0;
    assign pif.paint_color = r_color;
    assign idle            = (r_state == ST_IDLE) && !r_pend_move && !r_pend_clear;

endmodule

// File: tb/tb_piece_redraw_seq.sv
// Bench for piece_redraw_seq: painter model, job-list scoreboard, directed scenarios.
// Latency: n/a.
// Backpressure: painter model holds busy 3 cycles after each kick, then pulses done.
module tb_piece_redraw_seq;
    import redraw_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_move = 1'b0;
    logic        req_clear = 1'b0;
    logic [15:0] cur_x;
    logic [19:0] cur_y;
    logic [8:0]  piece_color;
    logic [8:0]  bg_color;
    logic        idle;

    always #5 clk = ~clk;

    piece_redraw_seq_if #(.COLOR_W(9)) pif ();

    piece_redraw_seq #(
        .NCELLS(4), .GRID_W(10), .GRID_H(20), .XW(4), .YW(5),
        .CELL_W_LOG2(6), .CELL_H(24), .COLOR_W(9), .CLEAR_ON_RESET(1)
    ) u_dut (
        .CLOCK_50    (clk),
        .resetn      (rst_n),
        .req_move    (req_move),
        .req_clear   (req_clear),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .piece_color (piece_color),
        .bg_color    (bg_color),
        .pif         (pif),
        .idle        (idle)
    );

    // ---------------- painter model ----------------
    int p_cnt = 0;
    initial begin
        pif.painter_busy = 1'b0;
        pif.painter_done = 1'b0;
    end
    always @(negedge clk) begin
        pif.painter_done = 1'b0;
        if (pif.kick === 1'b1) begin
            pif.painter_busy = 1'b1;
            p_cnt = 3;
        end else if (pif.painter_busy) begin
            p_cnt--;
            if (p_cnt == 0) begin
                pif.painter_busy = 1'b0;
                pif.painter_done = 1'b1;
            end
        end
    end

    // ---------------- reference model: list of expected jobs ----------------
    typedef struct { int x; int y; int c; } job_t;
    job_t exp_q[$];
    job_t cur_job;
    int   m_prev_x[4], m_prev_y[4], m_new_x[4], m_new_y[4];
    bit   m_prev_valid = 1'b0;

    int checks = 0, errors = 0, kicks = 0, last_x = -1, last_y = -1;
    bit prev_kick = 1'b0;

    function automatic bit on_board(input int cx, input int cy);
        return (cx < 10) && (cy < 20);
    endfunction

    task automatic plan_clear();
        for (int cy = 0; cy < 20; cy++)
            for (int cx = 0; cx < 10; cx++)
                exp_q.push_back('{cx * 64, cy * 24, int'(bg_color)});
        m_prev_valid = 1'b0;
    endtask

    task automatic plan_move(input int col);
        for (int i = 0; i < 4; i++) begin
            bit covered = 1'b0;
            for (int j = 0; j < 4; j++)
                if (m_prev_x[i] == m_new_x[j] && m_prev_y[i] == m_new_y[j]) covered = 1'b1;
            if (m_prev_valid && on_board(m_prev_x[i], m_prev_y[i]) && !covered)
                exp_q.push_back('{m_prev_x[i] * 64, m_prev_y[i] * 24, int'(bg_color)});
        end
        for (int i = 0; i < 4; i++)
            if (on_board(m_new_x[i], m_new_y[i]))
                exp_q.push_back('{m_new_x[i] * 64, m_new_y[i] * 24, col});
        for (int i = 0; i < 4; i++) begin
            m_prev_x[i] = m_new_x[i];
            m_prev_y[i] = m_new_y[i];
        end
        m_prev_valid = 1'b1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pif.kick === 1'b1) begin
                kicks++;
                last_x = int'(pif.x0);
                last_y = int'(pif.y0);
                checks++;
                if (prev_kick) begin
                    errors++;
                    $display("FAIL kick_gap: kick high two cycles running at kick %0d", kicks);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_kick: got (%0d,%0d,c=%0d), required no kick",
                             pif.x0, pif.y0, pif.paint_color);
                end else begin
                    cur_job = exp_q.pop_front();
                    if (int'(pif.x0) != cur_job.x || int'(pif.y0) != cur_job.y ||
                        int'(pif.paint_color) != cur_job.c) begin
                        errors++;
                        $display("FAIL job_%0d: got (%0d,%0d,c=%0d) required (%0d,%0d,c=%0d)",
                                 kicks, pif.x0, pif.y0, pif.paint_color,
                                 cur_job.x, cur_job.y, cur_job.c);
                    end
                end
            end
            prev_kick = pif.kick;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic set_cur(input int x0_, y0_, x1_, y1_, x2_, y2_, x3_, y3_);
        m_new_x = '{x0_, x1_, x2_, x3_};
        m_new_y = '{y0_, y1_, y2_, y3_};
        for (int i = 0; i < 4; i++) begin
            cur_x[i*4 +: 4] = 4'(m_new_x[i]);
            cur_y[i*5 +: 5] = 5'(m_new_y[i]);
        end
    endtask

    task automatic pulse_move();
        @(negedge clk); req_move = 1'b1;
        @(negedge clk); req_move = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); req_clear = 1'b1;
        @(negedge clk); req_clear = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_reached"}, int'(idle), 1);
        chk({nm, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_kicks(input string nm, input int target, input int budget);
        int n = 0;
        while (kicks < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_kick_reached"}, int'(kicks >= target), 1);
    endtask

    // ---------------- directed scenarios ----------------
    int base;
    initial begin
        rst_n       = 1'b0;
        bg_color    = 9'h012;
        piece_color = COLOR_MAGENTA;
        set_cur(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_kick", int'(pif.kick), 0);
        chk("rst_x0", int'(pif.x0), 0);
        chk("rst_y0", int'(pif.y0), 0);
        chk("rst_color", int'(pif.paint_color), 0);
        chk("rst_idle", int'(idle), 0);

        // Power-up clear
        plan_clear();
        rst_n = 1'b1;
        wait_idle("clear", 3000);
        chk("clear_kicks", kicks, 200);
        chk("clear_last_x", last_x, 576);
        chk("clear_last_y", last_y, 456);

        // First move: draw only, plus request-to-kick latency
        set_cur(4, 0, 5, 0, 4, 1, 5, 1);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        @(negedge clk);
        chk("lat_t1_kick", int'(pif.kick), 0);
        @(negedge clk);
        chk("lat_t2_kick", int'(pif.kick), 1);
        chk("first_draw_x0", int'(pif.x0), 256);
        chk("first_draw_y0", int'(pif.y0), 0);
        chk("first_draw_color", int'(pif.paint_color), 9'h1C7);
        wait_idle("move1", 400);
        chk("move1_kicks", kicks - base, 4);

        // Gravity: overlapping cells are not erased
        set_cur(4, 1, 5, 1, 4, 2, 5, 2);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        wait_idle("gravity", 400);
        chk("gravity_kicks", kicks - base, 6);

        // Coalescing: three requests during DRAW give one redraw with the last inputs
        set_cur(5, 2, 6, 2, 5, 3, 6, 3);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        wait_kicks("coal_first_draw", base + 4, 400);
        set_cur(7, 7, 8, 7, 7, 8, 8, 8);
        pulse_move();
        set_cur(0, 9, 1, 9, 0, 10, 1, 10);
        pulse_move();
        set_cur(5, 3, 6, 3, 5, 4, 6, 4);
        pulse_move();
        plan_move(int'(piece_color));
        wait_idle("coalesce", 600);
        chk("coalesce_kicks", kicks - base, 13);

        // Clear mid-ERASE, plus a move queued behind it (draws without erase)
        set_cur(0, 0, 1, 0, 2, 0, 3, 0);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        wait_kicks("midclr_first_erase", base + 1, 400);
        pulse_clear();
        plan_clear();
        piece_color = 9'h0AB;
        set_cur(4, 5, 5, 5, 6, 5, 7, 5);
        pulse_move();
        plan_move(int'(piece_color));
        wait_idle("midclear", 3000);
        chk("midclear_kicks", kicks - base, 212);

        // Off-board cells are skipped on draw and on the following erase
        set_cur(12, 3, 1, 3, 2, 20, 3, 3);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        wait_idle("oob_draw", 400);
        chk("oob_draw_kicks", kicks - base, 6);

        set_cur(1, 3, 2, 3, 12, 0, 3, 19);
        plan_move(int'(piece_color));
        base = kicks;
        pulse_move();
        wait_idle("oob_erase", 400);
        chk("oob_erase_kicks", kicks - base, 4);
        chk("oob_last_y", last_y, 456);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_redraw_seq.md
# piece_redraw_seq

Parametrised redraw sequencer between the game FSM and the `render_box20` painter. It generalises the single-cell erase/draw sequencing to an N-cell piece, with a full-board clear mode and request coalescing. It skips erasing cells that the new piece still covers. It issues one painter job at a time over the kick/busy/done handshake.

## Interface
- `NCELLS`, 4: cells per piece.
- `GRID_W`, 10: board columns.
- `GRID_H`, 20: board rows.
- `XW`, 4: cell x width.
- `YW`, 5: cell y width.
- `CELL_W_LOG2`, 6: pixel x = cx << 6.
- `CELL_H`, 24: pixel y = cy * 24.
- `COLOR_W`, 9: colour width.
- `CLEAR_ON_RESET`, 1: enter CLEAR after reset.
- `CLOCK_50`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_move`  in  1  1-cycle pulse: piece moved, rotated or fell.
- `req_clear`  in  1  1-cycle pulse: repaint whole board with `bg_color`.
- `cur_x`  in  NCELLS*XW  packed new cell columns; cell i = bits [i*XW +: XW].
- `cur_y`  in  NCELLS*YW  packed new cell rows.
- `piece_color`  in  COLOR_W  draw colour.
- `bg_color`  in  COLOR_W  erase/clear colour.
- `painter_busy`  in  1  painter job active.
- `painter_done`  in  1  1-cycle pulse: job finished.
- `kick`  out  1  1-cycle job start.
- `x0`  out  10  job pixel x.
- `y0`  out  9  job pixel y.
- `paint_color`  out  COLOR_W  job colour.
- `idle`  out  1  high in IDLE with no pending request.

## Operation
- States: IDLE, CLEAR, ERASE, DRAW. Each busy state alternates ISSUE and WAIT sub-phases.
- ISSUE:
  - Kick only when `painter_busy`=0 and `kick` was 0 in the previous cycle.
  - On kick, drive `x0`, `y0` and `paint_color` with the job.
  - Then go to WAIT.
- WAIT: leave on `painter_done`, then advance to the next job.
- IDLE:
  - Pending clear has priority: go to CLEAR.
  - Otherwise, a pending move snapshots `cur_x`, `cur_y` and `piece_color` into new-cell registers.
  - Then go to ERASE if `prev_valid`=1, else to DRAW.
- CLEAR:
  - Raster scan (cx 0..GRID_W-1 inner, cy 0..GRID_H-1 outer) in `bg_color`.
  - At end: `prev_valid`=0; return to IDLE.
- ERASE:
  - For i=0..NCELLS-1, paint prev cell i in `bg_color`.
  - Skip without a kick (zero cycles) if it equals any snapshotted new cell.
- DRAW:
  - Paint new cell i in the snapshotted colour.
  - At end: prev cells ← new cells, `prev_valid`=1, go to IDLE.
- Out-of-range cells (cx≥GRID_W or cy≥GRID_H) are skipped in both ERASE and DRAW.
- Request latching:
  - `req_move` and `req_clear` set sticky pending flags in any state, including during operation.
  - Multiple moves coalesce into one redraw using inputs sampled at the IDLE snapshot.
  - A `req_clear` arriving mid ERASE/DRAW is served after the current DRAW completes.
  - A pending move behind a clear then draws without erase.
- Arithmetic: `x0` = cx<<CELL_W_LOG2, truncated to 10 bits; `y0` = cy*CELL_H, truncated to 9 bits.
- `painter_done` outside WAIT is ignored.

## Timing
- Reset values:
  - Outputs: `kick`=0, `x0`=0, `y0`=0, `paint_color`=0.
  - `idle`=1 if CLEAR_ON_RESET=0, else 0.
  - State: IDLE, `prev_valid`=0, move pending flag cleared.
  - Clear pending flag = CLEAR_ON_RESET.
- Reset asserted mid-job abandons the job immediately. The painter is not aborted; the sequencer waits for `painter_busy`=0 before its next kick.
- Latency:
  - A request at cycle t in IDLE with the painter free reaches IDLE decision at t+1 and gives the first kick at t+2.
  - The next kick comes no earlier than 1 cycle after `painter_done`.
- Kick count per move = unskipped erases + in-range draws, at most 2*NCELLS. A full clear is exactly GRID_W*GRID_H kicks.
- `req_move` and `req_clear` in the same cycle: both latch; clear is served first.

## Structure
- Package `redraw_pkg`: state enum, sub-phase enum, `MAX_CELLS`, and default colour constants (bg 0, magenta 9'b111_000_111).
- Sub-module `cell_to_pixel`: combinational cx/cy → x0/y0 using CELL_W_LOG2 and CELL_H. It is instantiated once and fed by the current job mux.
- The overlap comparator for erase-skip (NCELLS×NCELLS equality) stays inline.

## Test plan
- Reset with CLEAR_ON_RESET=1 and a painter model (busy 3 cycles, then done) → exactly 200 kicks in bg, the last at (576,456). Then `idle`=1.
- First move to cells (4,0),(5,0),(4,1),(5,1) → 4 draw kicks only (no erase) at x0=256/320, y0=0/24.
- Gravity to (4,1),(5,1),(4,2),(5,2) → 2 erase kicks ((4,0),(5,0)) then 4 draw kicks. The overlapping cells are not erased.
- Three `req_move` pulses during an ongoing DRAW → exactly one further redraw, using `cur_x`/`cur_y` at the IDLE snapshot.
- `req_clear` mid ERASE → the current redraw completes, then 200 clear kicks, then the next move gives draws with no erase.
- A cell with cx=12 or cy=20 → no kick for that cell; other cells are painted normally.
